// File: rtl/esl_clk_check_freq_mon.sv
// Per-channel window-count checker: compares each end-of-window count against
// low/high thresholds and latches a fault after FAIL_PERSIST consecutive failing windows.
// Optional per-channel window-timeout watchdog is built only when ESL_CLK_CHECK_TIMEOUT_EN is defined.
module esl_clk_check_freq_mon #(
  parameter int NUM_CH       = 4,
  parameter int BIT_WD       = 24,
  parameter     LO_COUNT_THR = 25'd16,
  parameter     HI_COUNT_THR = 25'd32,
  parameter int FAIL_PERSIST = 3,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            count_vld,
  input  logic [NUM_CH*(BIT_WD+1)-1:0] count_val,
  input  logic [NUM_CH-1:0]            fault_clr,
  output logic [NUM_CH-1:0]            too_high,
  output logic [NUM_CH-1:0]            too_low,
  output logic [NUM_CH-1:0]            status_vld,
  output logic [NUM_CH-1:0]            fault,
  output logic                         param_error
);

  localparam int CNT_W = BIT_WD + 1;
  localparam int FC_W  = (FAIL_PERSIST < 2) ? 1 : $clog2(FAIL_PERSIST + 1);

  localparam logic [CNT_W-1:0] LO_T   = CNT_W'(LO_COUNT_THR);
  localparam logic [CNT_W-1:0] HI_T   = CNT_W'(HI_COUNT_THR);
  localparam logic [FC_W-1:0]  FP_SAT = FC_W'(FAIL_PERSIST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OK      = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_FAULT   = 2'd3
  } ch_state_t;

  // Untruncated thresholds on purpose: an inconsistent configuration is flagged as written.
  assign param_error = (LO_COUNT_THR > HI_COUNT_THR) || (FAIL_PERSIST < 1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_t        state_reg, state_next;
    logic [FC_W-1:0]  fail_cnt_reg, fail_cnt_next;
    logic [FC_W-1:0]  fail_inc;
    logic             too_high_reg, too_high_next;
    logic             too_low_reg, too_low_next;
    logic             status_reg, status_next;
    logic             fault_reg, fault_next;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             sample_take;
    logic             sample_hi;
    logic             sample_lo;

    assign cnt = count_val[gi*CNT_W +: CNT_W];

`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

    assign timeout_hit = (to_cnt_reg == TO_LAST);

    always_comb begin
      to_cnt_next = to_cnt_reg + 1'b1;
      if (fault_clr[gi] || count_vld[gi] || timeout_hit) begin
        to_cnt_next = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_next;
      end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A timeout with no real strobe behaves as a too-low window.
    assign sample_take = count_vld[gi] | timeout_hit;
    assign sample_hi   = count_vld[gi] & (cnt > HI_T);
    assign sample_lo   = count_vld[gi] ? (cnt < LO_T) : 1'b1;
    assign fail_inc    = (fail_cnt_reg >= FP_SAT) ? fail_cnt_reg : fail_cnt_reg + 1'b1;

    always_comb begin
      state_next    = state_reg;
      fail_cnt_next = fail_cnt_reg;
      too_high_next = too_high_reg;
      too_low_next  = too_low_reg;
      status_next   = 1'b0;
      fault_next    = fault_reg;
      if (fault_clr[gi]) begin
        state_next    = ST_IDLE;
        fail_cnt_next = '0;
        too_high_next = 1'b0;
        too_low_next  = 1'b0;
        fault_next    = 1'b0;
      end else if (sample_take) begin
        too_high_next = sample_hi;
        too_low_next  = sample_lo;
        status_next   = 1'b1;
        if (sample_hi || sample_lo) begin
          fail_cnt_next = fail_inc;
          if ((state_reg == ST_FAULT) || (fail_inc >= FP_SAT)) begin
            state_next = ST_FAULT;
            fault_next = 1'b1;
          end else begin
            state_next = ST_SUSPECT;
          end
        end else if (state_reg != ST_FAULT) begin
          state_next    = ST_OK;
          fail_cnt_next = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg    <= ST_IDLE;
        fail_cnt_reg <= '0;
        too_high_reg <= 1'b0;
        too_low_reg  <= 1'b0;
        status_reg   <= 1'b0;
        fault_reg    <= 1'b0;
      end else begin
        state_reg    <= state_next;
        fail_cnt_reg <= fail_cnt_next;
        too_high_reg <= too_high_next;
        too_low_reg  <= too_low_next;
        status_reg   <= status_next;
        fault_reg    <= fault_next;
      end
    end

    assign too_high[gi]   = too_high_reg;
    assign too_low[gi]    = too_low_reg;
    assign status_vld[gi] = status_reg;
    assign fault[gi]      = fault_reg | param_error;
  end

endmodule

// File: tb/tb_esl_clk_check_freq_mon.sv
// Directed self-checking bench for esl_clk_check_freq_mon (default 4-channel build plus
// a second instance with inconsistent thresholds to exercise param_error).
module tb_esl_clk_check_freq_mon;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 25;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_CH-1:0]         count_vld;
  logic [NUM_CH*CNT_W-1:0]   count_val;
  logic [NUM_CH-1:0]         fault_clr;
  logic [NUM_CH-1:0]         too_high, too_low, status_vld, fault;
  logic                      param_error;
  logic [NUM_CH-1:0]         bad_too_high, bad_too_low, bad_status_vld, bad_fault;
  logic                      bad_param_error;

  int total = 0;
  int bad   = 0;

  esl_clk_check_freq_mon dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_vld   (count_vld),
    .count_val   (count_val),
    .fault_clr   (fault_clr),
    .too_high    (too_high),
    .too_low     (too_low),
    .status_vld  (status_vld),
    .fault       (fault),
    .param_error (param_error)
  );

  esl_clk_check_freq_mon #(
    .LO_COUNT_THR (25'd40),
    .HI_COUNT_THR (25'd32)
  ) dut_bad (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_vld   (count_vld),
    .count_val   (count_val),
    .fault_clr   (fault_clr),
    .too_high    (bad_too_high),
    .too_low     (bad_too_low),
    .status_vld  (bad_status_vld),
    .fault       (bad_fault),
    .param_error (bad_param_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One window on one channel; returns #1 after the sampling edge.
  task automatic send(input int ch, input int val);
    logic [CNT_W-1:0] v;
    v = CNT_W'(val);
    count_vld[ch] = 1'b1;
    count_val[ch*CNT_W +: CNT_W] = v;
    @(posedge clk);
    #1;
    count_vld = '0;
    $display("txn ch=%0d count=%0d -> hi=%b lo=%b vld=%b fault=%b",
             ch, val, too_high, too_low, status_vld, fault);
  endtask

  task automatic clear(input logic [NUM_CH-1:0] mask);
    fault_clr = mask;
    @(posedge clk);
    #1;
    fault_clr = '0;
    $display("txn clear mask=%b -> hi=%b lo=%b vld=%b fault=%b",
             mask, too_high, too_low, status_vld, fault);
  endtask

  initial begin
    int pulses;
    int exp_pulses;
    rst_n     = 1'b0;
    count_vld = '0;
    count_val = '0;
    fault_clr = '0;

    // Strobe held during reset must be ignored.
    count_vld[0] = 1'b1;
    count_val[0 +: CNT_W] = 25'd40;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_too_high", too_high, 4'b0000);
    check_eq("rst_too_low", too_low, 4'b0000);
    check_eq("rst_status_vld", status_vld, 4'b0000);
    check_eq("rst_fault", fault, 4'b0000);
    check_eq("rst_param_error", param_error, 1'b0);
    check_eq("bad_rst_param_error", bad_param_error, 1'b1);
    check_eq("bad_rst_fault", bad_fault, 4'b1111);
    rst_n     = 1'b1;
    count_vld = '0;
    @(posedge clk);
    #1;
    check_eq("post_rst_status_vld", status_vld, 4'b0000);

    // ch0: in-range and both boundaries pass
    send(0, 20);
    check_eq("ch0_20_vld", status_vld, 4'b0001);
    check_eq("ch0_20_flags", {too_high[0], too_low[0]}, 2'b00);
    send(0, 16);
    check_eq("ch0_16_vld", status_vld, 4'b0001);
    check_eq("ch0_16_flags", {too_high[0], too_low[0]}, 2'b00);
    send(0, 32);
    check_eq("ch0_32_vld", status_vld, 4'b0001);
    check_eq("ch0_32_flags", {too_high[0], too_low[0]}, 2'b00);
    check_eq("ch0_fault", fault, 4'b0000);
    @(posedge clk);
    #1;
    check_eq("ch0_idle_vld", status_vld, 4'b0000);

    // ch0: just-outside boundaries fail, then a pass clears the streak
    send(0, 15);
    check_eq("ch0_15_flags", {too_high[0], too_low[0]}, 2'b01);
    send(0, 33);
    check_eq("ch0_33_flags", {too_high[0], too_low[0]}, 2'b10);
    send(0, 20);
    check_eq("ch0_pass_flags", {too_high[0], too_low[0]}, 2'b00);
    check_eq("ch0_no_fault", fault, 4'b0000);

    // ch1: three too-high windows latch fault
    send(1, 40);
    check_eq("ch1_40a_hi", too_high, 4'b0010);
    check_eq("ch1_40a_fault", fault, 4'b0000);
    send(1, 40);
    check_eq("ch1_40b_hi", too_high, 4'b0010);
    check_eq("ch1_40b_fault", fault, 4'b0000);
    send(1, 40);
    check_eq("ch1_40c_hi", too_high, 4'b0010);
    check_eq("ch1_40c_vld", status_vld, 4'b0010);
    check_eq("ch1_40c_fault", fault, 4'b0010);

    // ch2: pass in the middle breaks the fail streak
    send(2, 10);
    send(2, 10);
    send(2, 20);
    send(2, 10);
    send(2, 10);
    check_eq("ch2_lo", too_low, 4'b0100);
    check_eq("ch2_fault", fault, 4'b0010);

    // ch1: clear wins over a coincident strobe
    count_vld[1] = 1'b1;
    count_val[1*CNT_W +: CNT_W] = 25'd20;
    clear(4'b0010);
    count_vld = '0;
    check_eq("ch1_clr_vld", status_vld, 4'b0000);
    check_eq("ch1_clr_fault", fault, 4'b0000);
    check_eq("ch1_clr_hi", too_high, 4'b0000);
    // back in IDLE with zeroed counter: needs three fresh fails again
    send(1, 40);
    send(1, 40);
    check_eq("ch1_refail2_fault", fault, 4'b0000);
    send(1, 40);
    check_eq("ch1_refail3_fault", fault, 4'b0010);
    clear(4'b0010);
    check_eq("ch1_clr2_fault", fault, 4'b0000);

    // Simultaneous events on two channels stay independent
    count_vld = 4'b1001;
    count_val[0 +: CNT_W]       = 25'd40;
    count_val[3*CNT_W +: CNT_W] = 25'd10;
    @(posedge clk);
    #1;
    count_vld = '0;
    $display("txn ch=0,3 count=40,10 -> hi=%b lo=%b vld=%b fault=%b",
             too_high, too_low, status_vld, fault);
    check_eq("dual_vld", status_vld, 4'b1001);
    check_eq("dual_hi", too_high, 4'b0001);
    check_eq("dual_lo", too_low, 4'b1100);

    // Window timeout (watchdog only exists in the macro build)
    clear(4'b1111);
    check_eq("clr_all_lo", too_low, 4'b0000);
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    exp_pulses = 3;
`else
    exp_pulses = 0;
`endif
    pulses = 0;
    repeat (3*1024 + 16) begin
      @(posedge clk);
      #1;
      if (status_vld[3]) pulses++;
    end
    $display("txn ch3 silent for %0d cycles -> pulses=%0d lo=%b fault=%b",
             3*1024 + 16, pulses, too_low, fault);
    check_eq("ch3_timeout_pulses", pulses, exp_pulses);
`ifdef ESL_CLK_CHECK_TIMEOUT_EN
    check_eq("ch3_timeout_lo", too_low[3], 1'b1);
    check_eq("ch3_timeout_hi", too_high[3], 1'b0);
    check_eq("ch3_timeout_fault", fault[3], 1'b1);
`else
    check_eq("ch3_timeout_lo", too_low, 4'b0000);
    check_eq("ch3_timeout_hi", too_high, 4'b0000);
    check_eq("ch3_timeout_fault", fault, 4'b0000);
`endif

    check_eq("bad_end_fault", bad_fault, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
